// File: rtl/servo_slew_ctrl.sv
// -----------------------------------------------------------------------------
// servo_slew_ctrl
//   Slew-rate limiter in front of the servo PWM generator. Accepts a target
//   pulse width over a valid/ready handshake, clamps it to the legal range and
//   walks the output width toward it by at most STEP per PWM frame. The width
//   only changes on frame boundaries, so the PWM generator sees exactly one
//   width per frame. After the width has held at the target for HOLD_FRAMES
//   frames, a one-cycle done pulse is issued and the block returns to idle.
//
// Ports
//   clkin       system clock, rising edge
//   rstn        asynchronous active-low reset
//   tgt_in      requested width (unsigned)
//   tgt_valid   tgt_in is valid
//   tgt_ready   target can be accepted (idle or holding)
//   cntout      current width to the PWM generator (registered)
//   frame_tick  one-cycle pulse at each frame boundary (registered)
//   busy        high while ramping or holding
//   done        one-cycle pulse when the hold period completes
// -----------------------------------------------------------------------------
module servo_slew_ctrl #(
   parameter int unsigned FRAME_LEN   = 1500,
   parameter int unsigned MIN_W       = 50,
   parameter int unsigned MAX_W       = 250,
   parameter int unsigned INIT_W      = 150,
   parameter int unsigned STEP        = 1,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic       clkin,
   input  logic       rstn,
   input  logic [7:0] tgt_in,
   input  logic       tgt_valid,
   output logic       tgt_ready,
   output logic [7:0] cntout,
   output logic       frame_tick,
   output logic       busy,
   output logic       done
);

   localparam int unsigned FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   localparam logic [FCW-1:0] FC_LAST   = FCW'(FRAME_LEN - 1);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_FRAMES - 1);
   localparam logic [8:0]     MIN9      = 9'(MIN_W);
   localparam logic [8:0]     MAX9      = 9'(MAX_W);
   localparam logic [8:0]     STEP9     = 9'(STEP);
   localparam logic [7:0]     INIT8     = 8'(INIT_W);

   // Encoding is {busy, ramping}: busy and tgt_ready come straight off state
   // flops, so both are registered and glitch-free with no extra decode.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_HOLD = 2'b10,
      S_RAMP = 2'b11
   } state_e;

   state_e           state_q;
   logic [FCW-1:0]   fcnt_q;
   logic             frame_tick_q;
   logic [7:0]       cnt_q;
   logic [7:0]       target_q;
   logic [HCW-1:0]   hold_q;
   logic             done_q;

   logic [8:0]       clamp_d;
   logic [8:0]       next_w_d;
   logic [8:0]       tgt9;
   logic [8:0]       cur9;
   logic [8:0]       target9;
   logic [8:0]       diff9;
   logic [8:0]       mag9;
   logic             up;
   logic             xfer;

   assign xfer = tgt_valid & ~state_q[0];

   // Clamp and step arithmetic in 9 bits so differences never wrap.
   // NOTE: every combinational output gets a default before any branch;
   // otherwise a missed path infers a latch.
   always_comb begin
      tgt9    = {1'b0, tgt_in};
      cur9    = {1'b0, cnt_q};
      target9 = {1'b0, target_q};
      clamp_d = tgt9;
      if (tgt9 < MIN9)      clamp_d = MIN9;
      else if (tgt9 > MAX9) clamp_d = MAX9;
      up       = target9 > cur9;
      diff9    = up ? (target9 - cur9) : (cur9 - target9);
      // Partial last step: never overshoot the target.
      mag9     = (diff9 < STEP9) ? diff9 : STEP9;
      next_w_d = up ? (cur9 + mag9) : (cur9 - mag9);
   end

   // Free-running frame counter; the tick is registered, so it is high on the
   // cycle after the counter reads FRAME_LEN-1 (i.e. while it reads 0).
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         fcnt_q       <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= (fcnt_q == FC_LAST);
         if (fcnt_q == FC_LAST) fcnt_q <= '0;
         else                   fcnt_q <= fcnt_q + 1'b1;
      end
   end

   // Control FSM. A transfer takes priority over a coincident frame tick:
   // that tick neither moves the width nor counts as a hold frame.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         cnt_q    <= INIT8;
         target_q <= INIT8;
         hold_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (xfer) begin
            target_q <= clamp_d[7:0];
            hold_q   <= '0;
            state_q  <= (clamp_d == cur9) ? S_HOLD : S_RAMP;
         end else if (frame_tick_q) begin
            case (state_q)
               S_RAMP: begin
                  cnt_q <= next_w_d[7:0];
                  if (next_w_d == target9) begin
                     state_q <= S_HOLD;
                     hold_q  <= '0;
                  end
               end
               S_HOLD: begin
                  if (hold_q == HOLD_LAST) begin
                     done_q  <= 1'b1;
                     hold_q  <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     hold_q <= hold_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cntout     = cnt_q;
   assign frame_tick = frame_tick_q;
   assign busy       = state_q[1];
   assign tgt_ready  = ~state_q[0];
   assign done       = done_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// -----------------------------------------------------------------------------
// tb_servo_slew_ctrl
//   Two instances share clock, reset and target inputs: one with STEP=1, one
//   with STEP=4. A frame-level reference model (plain integer arithmetic on
//   width, target, mode and hold count; frame ticks derived from the number of
//   clocks since reset) predicts both. Directed scenarios check spec values
//   directly; a randomized phase compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_servo_slew_ctrl;

   localparam int FL     = 10;
   localparam int MIN_W  = 50;
   localparam int MAX_W  = 250;
   localparam int INIT_W = 150;
   localparam int HF     = 4;

   localparam int M_IDLE = 0;
   localparam int M_RAMP = 1;
   localparam int M_HOLD = 2;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] tgt_in;
   logic       tgt_valid;

   logic [7:0] a_cnt, b_cnt;
   logic       a_tick, b_tick, a_ready, b_ready, a_busy, b_busy, a_done, b_done;

   always #5 clk = ~clk;

   servo_slew_ctrl #(
      .FRAME_LEN(FL), .MIN_W(MIN_W), .MAX_W(MAX_W), .INIT_W(INIT_W),
      .STEP(1), .HOLD_FRAMES(HF)
   ) u_step1 (
      .clkin(clk), .rstn(rstn), .tgt_in(tgt_in), .tgt_valid(tgt_valid),
      .tgt_ready(a_ready), .cntout(a_cnt), .frame_tick(a_tick),
      .busy(a_busy), .done(a_done)
   );

   servo_slew_ctrl #(
      .FRAME_LEN(FL), .MIN_W(MIN_W), .MAX_W(MAX_W), .INIT_W(INIT_W),
      .STEP(4), .HOLD_FRAMES(HF)
   ) u_step4 (
      .clkin(clk), .rstn(rstn), .tgt_in(tgt_in), .tgt_valid(tgt_valid),
      .tgt_ready(b_ready), .cntout(b_cnt), .frame_tick(b_tick),
      .busy(b_busy), .done(b_done)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   int m_w    [2];
   int m_tgt  [2];
   int m_mode [2];
   int m_hold [2];
   bit m_done [2];
   int m_n;                       // rising edges since reset release
   int step_of [2] = '{1, 4};

   function automatic bit m_tick();
      return (m_n > 0) && (m_n % FL == 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_w[i]    = INIT_W;
         m_tgt[i]  = INIT_W;
         m_mode[i] = M_IDLE;
         m_hold[i] = 0;
         m_done[i] = 1'b0;
      end
      m_n = 0;
   endtask

   task automatic model_edge();
      bit t;
      int v, c, d, mv;
      t = m_tick();
      v = int'(tgt_in);
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (tgt_valid && m_mode[i] != M_RAMP) begin
            c = (v < MIN_W) ? MIN_W : (v > MAX_W) ? MAX_W : v;
            m_tgt[i]  = c;
            m_hold[i] = 0;
            m_mode[i] = (c == m_w[i]) ? M_HOLD : M_RAMP;
         end else if (t) begin
            if (m_mode[i] == M_RAMP) begin
               d  = m_tgt[i] - m_w[i];
               mv = (d < 0) ? -d : d;
               if (mv > step_of[i]) mv = step_of[i];
               m_w[i] = m_w[i] + ((d < 0) ? -mv : mv);
               if (m_w[i] == m_tgt[i]) begin
                  m_mode[i] = M_HOLD;
                  m_hold[i] = 0;
               end
            end else if (m_mode[i] == M_HOLD) begin
               m_hold[i]++;
               if (m_hold[i] == HF) begin
                  m_done[i] = 1'b1;
                  m_mode[i] = M_IDLE;
               end
            end
         end
      end
      m_n++;
   endtask

   // ---------------- stimulus plumbing ----------------
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic reset_assert();
      tgt_valid = 1'b0;
      rstn      = 1'b0;
      model_reset();
      #3;
   endtask

   task automatic reset_release();
      @(negedge clk);
      rstn = 1'b1;
      m_n  = 0;
   endtask

   task automatic fresh_reset();
      reset_assert();
      reset_release();
   endtask

   task automatic send(input int v);
      tgt_in    = 8'(v);
      tgt_valid = 1'b1;
      cycle();
      tgt_valid = 1'b0;
      tgt_in    = 8'($urandom);
   endtask

   // Advance through the next frame tick and the edge that acts on it.
   task automatic wait_tick();
      int k = 0;
      while (a_tick !== 1'b1 && k < 3 * FL) begin
         cycle();
         k++;
      end
      n_vec++;
      if (a_tick !== 1'b1) begin
         n_err++;
         $display("FAIL tick_timeout: no frame_tick within %0d clocks", 3 * FL);
      end
      cycle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      fresh_reset();
      send(170);
      repeat (13) cycle();
      reset_assert();
      n_vec++;
      if ({a_cnt, b_cnt} !== {8'd150, 8'd150}) begin
         n_err++;
         $display("FAIL reset_cnt: got %0d/%0d want 150/150", a_cnt, b_cnt);
      end
      n_vec++;
      if ({a_busy, a_ready, a_done, a_tick, b_busy, b_ready, b_done, b_tick} !== 8'b0100_0100) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 01000100",
                  {a_busy, a_ready, a_done, a_tick, b_busy, b_ready, b_done, b_tick});
      end
      reset_release();
      for (int n = 1; n <= 3 * FL; n++) begin
         cycle();
         n_vec++;
         if (a_tick !== (n % FL == 0) || b_tick !== (n % FL == 0)) begin
            n_err++;
            $display("FAIL tick_period: clk %0d got %b/%b want %b", n, a_tick, b_tick, n % FL == 0);
         end
      end
   endtask

   task automatic test_basic_ramp();
      fresh_reset();
      send(160);
      n_vec++;
      if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
         n_err++;
         $display("FAIL ramp_entry: ready/busy got %b%b want 01", a_ready, a_busy);
      end
      for (int k = 1; k <= 10; k++) begin
         wait_tick();
         n_vec++;
         if (a_cnt !== 8'(150 + k)) begin
            n_err++;
            $display("FAIL ramp_cnt: tick %0d got %0d want %0d", k, a_cnt, 150 + k);
         end
      end
      n_vec++;
      if (a_ready !== 1'b1 || a_busy !== 1'b1) begin
         n_err++;
         $display("FAIL hold_entry: ready/busy got %b%b want 11", a_ready, a_busy);
      end
      for (int k = 1; k <= HF; k++) begin
         wait_tick();
         n_vec++;
         if (a_done !== (k == HF) || a_cnt !== 8'd160) begin
            n_err++;
            $display("FAIL hold_done: tick %0d done %b cnt %0d want %b/160", k, a_done, a_cnt, k == HF);
         end
      end
      n_vec++;
      if (a_busy !== 1'b0 || a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_after_done: busy/ready got %b%b want 01", a_busy, a_ready);
      end
      cycle();
      n_vec++;
      if (a_done !== 1'b0) begin
         n_err++;
         $display("FAIL done_width: done still %b want 0", a_done);
      end
   endtask

   task automatic test_clamp_partial();
      int exp_dn [3] = '{146, 142, 141};
      int lim [2] = '{255, 10};
      int want [2] = '{250, 50};
      for (int c = 0; c < 2; c++) begin
         fresh_reset();
         send(lim[c]);
         for (int k = 0; k < 40 && b_ready !== 1'b1; k++) wait_tick();
         n_vec++;
         if (b_cnt !== 8'(want[c]) || b_busy !== 1'b1 || b_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clamp: req %0d got cnt %0d busy %b ready %b want %0d/1/1",
                     lim[c], b_cnt, b_busy, b_ready, want[c]);
         end
      end
      fresh_reset();
      send(157);
      wait_tick();
      n_vec++;
      if (b_cnt !== 8'd154) begin
         n_err++;
         $display("FAIL step4_up1: got %0d want 154", b_cnt);
      end
      wait_tick();
      n_vec++;
      if (b_cnt !== 8'd157 || b_ready !== 1'b1) begin
         n_err++;
         $display("FAIL step4_up2: got %0d ready %b want 157/1", b_cnt, b_ready);
      end
      fresh_reset();
      send(141);
      for (int k = 0; k < 3; k++) begin
         wait_tick();
         n_vec++;
         if (b_cnt !== 8'(exp_dn[k])) begin
            n_err++;
            $display("FAIL step4_down: tick %0d got %0d want %0d", k + 1, b_cnt, exp_dn[k]);
         end
      end
   endtask

   task automatic test_handshake_edges();
      fresh_reset();
      send(200);
      wait_tick();
      tgt_in    = 8'd100;
      tgt_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         n_vec++;
         if (a_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_ready: got %b want 0", a_ready);
         end
      end
      tgt_valid = 1'b0;
      wait_tick();
      n_vec++;
      if (a_cnt !== 8'd152) begin
         n_err++;
         $display("FAIL ramp_ignore: got %0d want 152", a_cnt);
      end
      // Retarget while holding, on the very edge that carries a frame tick.
      fresh_reset();
      send(152);
      wait_tick();
      wait_tick();
      for (int k = 0; k < 3 * FL && a_tick !== 1'b1; k++) cycle();
      send(120);
      n_vec++;
      if ({a_done, b_done, a_ready, b_ready} !== 4'b0000 || a_cnt !== 8'd152 || b_cnt !== 8'd152) begin
         n_err++;
         $display("FAIL hold_retarget: done %b%b ready %b%b cnt %0d/%0d want 00 00 152/152",
                  a_done, b_done, a_ready, b_ready, a_cnt, b_cnt);
      end
      wait_tick();
      n_vec++;
      if (a_cnt !== 8'd151 || b_cnt !== 8'd148) begin
         n_err++;
         $display("FAIL retarget_down: got %0d/%0d want 151/148", a_cnt, b_cnt);
      end
   endtask

   task automatic test_equal_target();
      fresh_reset();
      send(150);
      n_vec++;
      if ({a_busy, a_ready, b_busy, b_ready} !== 4'b1111) begin
         n_err++;
         $display("FAIL equal_hold: busy/ready got %b want 1111", {a_busy, a_ready, b_busy, b_ready});
      end
      for (int k = 1; k <= HF; k++) begin
         wait_tick();
         n_vec++;
         if (a_cnt !== 8'd150 || a_done !== (k == HF) || b_done !== (k == HF)) begin
            n_err++;
            $display("FAIL equal_done: tick %0d cnt %0d done %b%b want 150 %b", k, a_cnt, a_done, b_done, k == HF);
         end
      end
   endtask

   task automatic test_reset_mid_ramp();
      fresh_reset();
      send(200);
      repeat (5) wait_tick();
      n_vec++;
      if (a_cnt !== 8'd155) begin
         n_err++;
         $display("FAIL mid_ramp_pre: got %0d want 155", a_cnt);
      end
      reset_assert();
      n_vec++;
      if (a_cnt !== 8'd150 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_ramp_reset: cnt %0d busy %b ready %b want 150/0/1", a_cnt, a_busy, a_ready);
      end
      reset_release();
      send(200);
      wait_tick();
      n_vec++;
      if (a_cnt !== 8'd151) begin
         n_err++;
         $display("FAIL mid_ramp_restart: got %0d want 151", a_cnt);
      end
   endtask

   task automatic test_random();
      logic [11:0] exp_v, got_v;
      int v;
      fresh_reset();
      for (int n = 0; n < 6000; n++) begin
         if ($urandom_range(0, 599) == 0) fresh_reset();
         tgt_valid = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) == 0) begin
            v = m_w[$urandom_range(0, 1)] + int'($urandom_range(0, 8)) - 4;
            tgt_in = 8'(v);
         end else begin
            tgt_in = 8'($urandom);
         end
         cycle();
         for (int i = 0; i < 2; i++) begin
            exp_v = {8'(m_w[i]), m_tick(), m_mode[i] != M_RAMP, m_mode[i] != M_IDLE, m_done[i]};
            got_v = (i == 0) ? {a_cnt, a_tick, a_ready, a_busy, a_done}
                             : {b_cnt, b_tick, b_ready, b_busy, b_done};
            n_vec++;
            if (got_v !== exp_v) begin
               n_err++;
               $display("FAIL random step%0d clk %0d: {cnt,tick,ready,busy,done} got %h want %h",
                        step_of[i], n, got_v, exp_v);
            end
         end
      end
   endtask

   initial begin
      tgt_in    = 8'd0;
      tgt_valid = 1'b0;
      rstn      = 1'b0;
      model_reset();
      test_reset();
      test_basic_ramp();
      test_clamp_partial();
      test_handshake_edges();
      test_equal_target();
      test_reset_mid_ramp();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/servo_slew_ctrl.md
Name: servo_slew_ctrl

Overview:
Upstream stage of the servo PWM generator. Accepts target pulse widths over a valid/ready handshake and produces the 8-bit width word `cntout` that feeds the PWM generator's width input. The width moves toward the target by a bounded step once per PWM frame, which limits servo slew rate and keeps the width stable within a frame. It reports busy while moving and settling, and pulses done once the output has held at the target for a set number of frames.

Parameters:
FRAME_LEN, 1500, clocks per PWM frame; must match the downstream PWM period.
MIN_W, 50, lowest legal width.
MAX_W, 250, highest legal width.
INIT_W, 150, width after reset (neutral position); MIN_W <= INIT_W <= MAX_W.
STEP, 1, maximum width change per frame; range 1..255.
HOLD_FRAMES, 4, frames to hold at target before done; must be >= 1.

Ports:
clkin  input  1  system clock; all logic on the rising edge.
rstn  input  1  reset, asynchronous, active-low.
tgt_in  input  8  requested width, unsigned.
tgt_valid  input  1  tgt_in is valid.
tgt_ready  output  1  block can accept a target.
cntout  output  8  current width to the PWM generator (registered).
frame_tick  output  1  one-cycle pulse at each frame boundary (registered).
busy  output  1  high when state is not IDLE.
done  output  1  one-cycle pulse when a move completes.

Behaviour:
- Reset (rstn=0, asynchronous) sets:
  - cntout=INIT_W;
  - frame counter=0, hold counter=0;
  - state=IDLE;
  - frame_tick=0, done=0, busy=0, tgt_ready=1.
- Frame counter:
  - free-runs 0..FRAME_LEN-1 and wraps to 0;
  - frame_tick=1 on the cycle after the counter reads FRAME_LEN-1;
  - period is exactly FRAME_LEN clocks in every state.
- Handshake:
  - transfer occurs on a clock edge with tgt_valid=1 and tgt_ready=1;
  - tgt_ready=1 in IDLE and HOLD, 0 in RAMP;
  - tgt_valid while tgt_ready=0 is ignored; nothing is latched;
  - accepted value is clamped to [MIN_W,MAX_W] and stored in the target register.
- States:
  - IDLE: on transfer, go to RAMP; if clamped target equals cntout, go to HOLD instead.
  - RAMP: on each frame_tick, cntout moves toward target by min(STEP,|target-cntout|). When the updated value equals target, go to HOLD with hold counter=0.
  - HOLD: each frame_tick increments the hold counter. When it reaches HOLD_FRAMES, done pulses for 1 cycle and state returns to IDLE.
  - HOLD with a transfer: hold counter clears, done is not pulsed, state goes to RAMP (or restarts HOLD if the new target equals cntout).
- cntout changes only on frame_tick cycles, so the downstream PWM sees one width per frame.
- Arithmetic:
  - compare and difference use 9-bit unsigned values; no wrap or underflow;
  - cntout always stays within [MIN_W,MAX_W];
  - a step never overshoots the target.
- Transfer coinciding with frame_tick:
  - the transfer takes priority;
  - that tick does not move cntout toward the new target; ramping starts at the next tick;
  - in HOLD, that tick is not counted.
- Reset mid-operation: cntout returns to INIT_W immediately and any pending target is discarded.
- Latency: transfer to first cntout change is at most FRAME_LEN+1 clocks.

Test Plan (FRAME_LEN=10 for simulation unless stated):
1. Reset: assert rstn=0 mid-frame -> cntout=150, busy=0, tgt_ready=1, done=0. Release -> frame_tick every 10 clocks.
2. Basic ramp: STEP=1, tgt_in=160 accepted in IDLE -> tgt_ready=0, cntout 151..160 on 10 consecutive ticks. Then 4 HOLD ticks, single-cycle done, busy=0, tgt_ready=1.
3. Clamp and partial step:
   - tgt_in=255 -> target 250; tgt_in=10 -> target 50;
   - STEP=4 from 150 to 157 -> cntout 154, then 157 (no overshoot);
   - STEP=4, downward 150 to 141 -> 146, 142, 141.
4. Handshake edges:
   - tgt_valid during RAMP -> ignored, target unchanged;
   - new target 120 accepted in HOLD on the same cycle as frame_tick -> no done, RAMP downward starting next tick.
5. Equal target: tgt_in=150 from reset -> straight to HOLD, cntout constant, done after 4 ticks.
6. Reset mid-ramp: at cntout=155 toward 200, pulse rstn low -> cntout=150, state IDLE. Re-issue target 200 -> ramp restarts from 150.
